// File: rtl/tmp10x_pkg.sv
// Shared types, constants and helpers for the TMP10x conversion controller.
package tmp10x_pkg;

    // Temperature width: two's complement, LSB = 0.0625 C.
    localparam int TEMP_W = 12;

    // Conversion scheduler states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CONV  = 3'd2,
        EVAL  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Consecutive-fault depth selected by F10: 1/2/4/6.
    function automatic logic [2:0] fault_depth(input logic [1:0] f);
        logic [2:0] n;
        case (f)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            2'd2:    n = 3'd4;
            default: n = 3'd6;
        endcase
        return n;
    endfunction

    // Resolution mask: keeps the top 9..12 bits, zeroing the low (3-r) bits.
    function automatic logic [TEMP_W-1:0] res_mask(input logic [1:0] r);
        logic [TEMP_W-1:0] m;
        case (r)
            2'd0:    m = 12'hFF8;
            2'd1:    m = 12'hFFC;
            2'd2:    m = 12'hFFE;
            default: m = 12'hFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmp10x_fault_queue.sv
// Fault queue with hysteresis: counts consecutive limit violations and
// drives the internal (pre-polarity) alert level.
module tmp10x_fault_queue
    import tmp10x_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_eval,
    input  logic [TEMP_W-1:0] i_temp,
    input  logic [TEMP_W-1:0] i_t_high,
    input  logic [TEMP_W-1:0] i_t_low,
    input  logic [1:0]        i_f10,
    input  logic              i_tm,
    input  logic              i_alert_clr,
    output logic [2:0]        o_fault_cnt,
    output logic              o_alert_int
);

    logic [2:0] r_cnt;
    logic       r_dir;      // 0 = seeking high limit, 1 = seeking low limit
    logic       r_alert;
    logic       r_tm_q;

    logic       w_over;
    logic       w_under;
    logic       w_hit;
    logic [2:0] w_inc;
    logic       w_reach;

    // Signed limit compares and the saturating next count.
    always_comb begin
        w_over  = $signed(i_temp) >= $signed(i_t_high);
        w_under = $signed(i_temp) <  $signed(i_t_low);
        w_hit   = r_dir ? w_under : w_over;
        w_inc   = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
        w_reach = w_hit && (w_inc >= fault_depth(i_f10));
    end

    // Counter, direction and alert update; a queue set overrides a clear.
    always_ff @(posedge i_clk) begin
        r_tm_q <= i_tm;
        if (i_rst) begin
            r_cnt   <= 3'd0;
            r_dir   <= 1'b0;
            r_alert <= 1'b0;
        end else if (i_tm != r_tm_q) begin
            r_cnt   <= 3'd0;
            r_dir   <= 1'b0;
            r_alert <= 1'b0;
        end else begin
            if (i_alert_clr && i_tm) begin
                r_alert <= 1'b0;
            end
            if (i_eval) begin
                if (w_reach) begin
                    r_cnt   <= 3'd0;
                    r_dir   <= ~r_dir;
                    r_alert <= i_tm ? 1'b1 : ~r_dir;
                end else if (w_hit) begin
                    r_cnt <= w_inc;
                end else begin
                    r_cnt <= 3'd0;
                end
            end
        end
    end

    assign o_fault_cnt = r_cnt;
    assign o_alert_int = r_alert;

endmodule

// File: rtl/tmp10x_conv_ctrl.sv
// TMP10x conversion scheduler: sequences ADC conversions in continuous,
// shutdown and one-shot modes, latches the masked result and feeds the
// fault queue. Temperature width comes from tmp10x_pkg::TEMP_W.
// ADC handshake: Adc_Start is a one-cycle request; the ADC answers with a
// one-cycle Adc_Valid strobe carrying Adc_Data (a later strobe overwrites);
// there is no back-pressure in either direction.
module tmp10x_conv_ctrl
    import tmp10x_pkg::*;
#(
    parameter int CONV_BASE_CYCLES = 4,
    parameter int GAP_CYCLES       = 16
)
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SD,
    input  logic              OS_Req,
    input  logic [1:0]        R10,
    input  logic [1:0]        F10,
    input  logic              TM,
    input  logic              POL,
    input  logic [TEMP_W-1:0] T_High,
    input  logic [TEMP_W-1:0] T_Low,
    input  logic              Alert_Clr,
    output logic              Adc_Start,
    input  logic [TEMP_W-1:0] Adc_Data,
    input  logic              Adc_Valid,
    output logic [TEMP_W-1:0] Temp_Reg,
    output logic              Temp_Valid,
    output logic              Busy,
    output logic              OS_Status,
    output logic              Alert,
    output logic [2:0]        Fault_Cnt,
    output logic [2:0]        Dbg_State
);

    localparam int CNT_W = 16;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_gap;
    logic [1:0]        r_lat;
    logic              r_got_valid;
    logic [TEMP_W-1:0] r_data;
    logic [TEMP_W-1:0] r_temp;
    logic              r_temp_valid;
    logic              r_oneshot;

    logic [CNT_W-1:0]  w_conv_len;
    logic              w_os_set;
    logic              w_conv_done;
    logic [TEMP_W-1:0] w_sample;
    logic              w_eval;
    logic              w_alert_int;

    // Next-state logic and per-state decode.
    always_comb begin
        w_next      = r_state;
        w_conv_len  = CNT_W'(CONV_BASE_CYCLES) << R10;
        w_os_set    = 1'b0;
        w_conv_done = 1'b0;
        w_sample    = Adc_Valid ? Adc_Data : r_data;
        case (r_state)
            IDLE: begin
                if (!SD) begin
                    w_next = START;
                end else if (OS_Req) begin
                    w_next   = START;
                    w_os_set = 1'b1;
                end
            end
            START: w_next = CONV;
            CONV: begin
                if (r_cnt == '0 && (r_got_valid || Adc_Valid)) begin
                    w_next      = EVAL;
                    w_conv_done = 1'b1;
                end
            end
            EVAL: begin
                if (r_oneshot || SD) begin
                    w_next = IDLE;
                end else begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (SD) begin
                    w_next = IDLE;
                end else if (r_gap == CNT_W'(GAP_CYCLES)) begin
                    w_next = START;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Conversion counters, result capture and one-shot bookkeeping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt        <= '0;
            r_gap        <= '0;
            r_lat        <= 2'd0;
            r_got_valid  <= 1'b0;
            r_data       <= '0;
            r_temp       <= '0;
            r_temp_valid <= 1'b0;
            r_oneshot    <= 1'b0;
        end else begin
            r_temp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_os_set) begin
                        r_oneshot <= 1'b1;
                    end
                end
                START: begin
                    r_lat       <= R10;
                    r_cnt       <= w_conv_len - CNT_W'(1);
                    r_got_valid <= 1'b0;
                end
                CONV: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (Adc_Valid) begin
                        r_data      <= Adc_Data;
                        r_got_valid <= 1'b1;
                    end
                    if (w_conv_done) begin
                        r_temp       <= w_sample & res_mask(r_lat);
                        r_temp_valid <= 1'b1;
                    end
                end
                EVAL: begin
                    r_oneshot <= 1'b0;
                    r_gap     <= '0;
                end
                GAP: r_gap <= r_gap + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign w_eval = (r_state == EVAL);

    tmp10x_fault_queue u_fault_queue (
        .i_clk       (Clk),
        .i_rst       (Rst),
        .i_eval      (w_eval),
        .i_temp      (r_temp),
        .i_t_high    (T_High),
        .i_t_low     (T_Low),
        .i_f10       (F10),
        .i_tm        (TM),
        .i_alert_clr (Alert_Clr),
        .o_fault_cnt (Fault_Cnt),
        .o_alert_int (w_alert_int)
    );

    assign Adc_Start  = (r_state == START);
    assign Busy       = (r_state == START) || (r_state == CONV) || (r_state == EVAL);
    assign OS_Status  = ~r_oneshot;
    assign Temp_Reg   = r_temp;
    assign Temp_Valid = r_temp_valid;
    assign Alert      = POL ? w_alert_int : ~w_alert_int;
    assign Dbg_State  = r_state;

endmodule

// File: doc/tmp10x_conv_ctrl.md
Name: tmp10x_conv_ctrl

Overview:
Conversion scheduler and alert controller for the TMP10x sensor model. It sequences ADC conversions in continuous, shutdown and one-shot modes, with conversion time scaled by resolution. It latches the resolution-masked temperature and runs the fault-queue / hysteresis alert logic against T_High/T_Low in comparator or interrupt mode. It sits between the I2C register file (config, limits) and the ADC/temperature datapath.

Parameters:
CONV_BASE_CYCLES, 4, conversion length in cycles at 9-bit resolution; each extra resolution bit doubles it (C = CONV_BASE_CYCLES << R10)
GAP_CYCLES, 16, idle cycles between conversions in continuous mode
TEMP_W, 12, temperature width (two's complement, LSB 0.0625 C)

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
SD  in  1  shutdown mode
OS_Req  in  1  one-shot request pulse; sampled only in IDLE with SD=1
R10  in  2  resolution: 00=9b, 01=10b, 10=11b, 11=12b
F10  in  2  fault queue depth select: 1/2/4/6 consecutive faults
TM  in  1  0=comparator, 1=interrupt mode
POL  in  1  alert polarity; 1=active-high
T_High  in  TEMP_W  upper limit, signed
T_Low  in  TEMP_W  lower (hysteresis) limit, signed
Alert_Clr  in  1  pulse: temperature-register read; clears alert in interrupt mode
Adc_Start  out  1  one-cycle conversion start pulse
Adc_Data  in  TEMP_W  ADC result
Adc_Valid  in  1  ADC result strobe, 1 cycle
Temp_Reg  out  TEMP_W  last masked result
Temp_Valid  out  1  one-cycle pulse on Temp_Reg update
Busy  out  1  high in START/CONV/EVAL
OS_Status  out  1  0 while a one-shot is pending, else 1
Alert  out  1  alert level after polarity
Fault_Cnt  out  3  consecutive-fault counter

Behaviour:
- Reset (synchronous): state=IDLE, Temp_Reg=0, Temp_Valid=0, Adc_Start=0, Busy=0, OS_Status=1, Fault_Cnt=0, alert_int=0, dir=0 (seeking high), oneshot=0. Alert = POL ? alert_int : ~alert_int (reset level = ~POL). Rst mid-conversion aborts it; a later Adc_Valid is ignored.
- IDLE: if SD=0 -> START. If SD=1 and OS_Req=1 -> START, set oneshot=1 and OS_Status=0. Otherwise stay.
- START (1 cycle): Adc_Start=1. Latch R10 into r_lat (changes to R10 apply from the next conversion). Load cnt=C-1. Clear got_valid. Go to CONV.
- CONV: decrement cnt. On Adc_Valid, capture Adc_Data and set got_valid; a later Adc_Valid overwrites. When cnt==0 and (got_valid or Adc_Valid): go to EVAL and, on that edge, set Temp_Reg = data with the low (3-r_lat) bits zeroed, and Temp_Valid=1. When cnt==0 without a valid result, hold in CONV. The minimum latency from Adc_Start to Temp_Valid is C+1 cycles.
- EVAL (1 cycle): apply one fault-queue update. If oneshot: clear oneshot, set OS_Status=1, go to IDLE. Else if SD: go to IDLE. Else go to GAP.
- GAP: count GAP_CYCLES, then go to START. SD=1 goes to IDLE on the next edge. SD rising during START/CONV lets the conversion finish.
- Fault queue, signed compares: over = Temp_Reg >= T_High; under = Temp_Reg < T_Low. Target N = {1,2,4,6}[F10].
  - dir=0: over -> Fault_Cnt+1, else Fault_Cnt=0.
  - dir=1: under -> Fault_Cnt+1, else Fault_Cnt=0.
  - Fault_Cnt saturates at 7.
  - On reaching >= N: Fault_Cnt=0, dir toggles. Comparator mode: alert_int = (new dir==1). Interrupt mode: alert_int=1.
- Alert_Clr: in TM=1, clears alert_int. In TM=0 it is ignored. A fault-queue set in the same cycle wins over Alert_Clr.
- Any TM change (registered edge detect): alert_int=0, dir=0, Fault_Cnt=0 on the next cycle.
- SD=1 in IDLE does not alter alert_int. F10 is sampled at each EVAL.

Decomposition:
- Shared package tmp10x_pkg: TEMP_W; state enum {IDLE, START, CONV, EVAL, GAP}; fault-depth table {1,2,4,6}; resolution-mask function (r -> 12-bit mask).
- Sub-module tmp10x_fault_queue: compares, Fault_Cnt, dir, alert_int, Alert_Clr/TM handling. Enabled by a one-cycle eval strobe from the FSM.

Test Plan:
- Rst then SD=0, R10=00, Adc_Valid with 0x7FF two cycles after Adc_Start -> Temp_Valid 5 cycles after Adc_Start, Temp_Reg=0x7F8; next Adc_Start 1+16+1 cycles after Temp_Valid.
- R10=11, Adc_Valid withheld until cycle 40 after Adc_Start -> FSM holds in CONV past cnt=0, Temp_Valid at cycle 41, Temp_Reg=Adc_Data unmasked.
- SD=1, OS_Req pulse -> OS_Status=0, exactly one conversion, Temp_Valid once, OS_Status=1, no further Adc_Start for 100 cycles; OS_Req with SD=0 is ignored.
- Comparator, F10=10, POL=0, T_High=0x500, T_Low=0x4B0; data 0x510 x3 then 0x400 -> Alert stays 1, Fault_Cnt 1,2,3,0. Then 0x510 x4 -> Alert=0. Then 0x400 x4 -> Alert=1.
- Interrupt, F10=00, POL=1: 0x510 -> Alert=1; Alert_Clr -> 0; 0x510 again -> no alert (dir=1); 0x400 -> Alert=1. Alert_Clr coincident with the setting EVAL -> Alert stays 1.
- SD asserted mid-CONV -> conversion completes with Temp_Valid, then IDLE. Rst mid-CONV -> all outputs at reset values next cycle and a stale Adc_Valid produces no Temp_Valid.
